seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_if.sv | 14 +
 rtl/seg7_scan.sv | 108 ++++++++++
 tb/tb_seg7_scan.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Upstream word channel for seg7_scan: BCD word, DP position and blanking flag
// under a valid/ready handshake.
interface seg7_scan_if #(
   parameter int DIGITS = 3
);
   logic [4*DIGITS-1:0] bcd;
   logic [3:0]          dp_pos;
   logic                blank_lz;
   logic                bcd_valid;
   logic                bcd_ready;

   modport master (output bcd, dp_pos, blank_lz, bcd_valid, input bcd_ready);
   modport slave  (input bcd, dp_pos, blank_lz, bcd_valid, output bcd_ready);
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: one pending word, swapped into the display only at frame ends.
// Outputs are registered (1 cycle); bcd_ready drops while a word waits for the next frame boundary.
module seg7_scan #(
   parameter int DIGITS  = 3,
   parameter int CLK_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_if.slave        up,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              dp
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DW-1:0]       div_cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] pend_bcd, disp_bcd;
   logic [3:0]          pend_dp, disp_dp;
   logic                pend_blz, disp_blz;
   logic                pend_full;

   logic                div_wrap, frame_end, xfer;
   logic [3:0]          digit;
   logic [3:0]          dp_eff;
   logic [DIGITS-1:0]   upper_zero;
   logic                zacc;
   logic                blank;
   logic [6:0]          seg_raw;

   assign div_wrap     = (div_cnt == DW'(CLK_DIV - 1));
   assign frame_end    = div_wrap && (idx == IW'(DIGITS - 1));
   assign up.bcd_ready = ~pend_full;
   assign xfer         = up.bcd_valid && !pend_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         idx       <= '0;
         pend_full <= 1'b0;
         pend_bcd  <= '0;
         pend_dp   <= '0;
         pend_blz  <= 1'b0;
         disp_bcd  <= '0;
         disp_dp   <= '0;
         disp_blz  <= 1'b0;
      end else begin
         if (div_wrap) begin
            div_cnt <= '0;
            idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
         // Pending full and a transfer are mutually exclusive, so a word
         // accepted on a boundary cycle waits a whole frame.
         if (frame_end && pend_full) begin
            disp_bcd  <= pend_bcd;
            disp_dp   <= pend_dp;
            disp_blz  <= pend_blz;
            pend_full <= 1'b0;
         end else if (xfer) begin
            pend_bcd  <= up.bcd;
            pend_dp   <= up.dp_pos;
            pend_blz  <= up.blank_lz;
            pend_full <= 1'b1;
         end
      end
   end

   always_comb begin
      digit      = disp_bcd[4*idx +: 4];
      dp_eff     = (disp_dp > 4'(DIGITS)) ? 4'd0 : disp_dp;
      upper_zero = '0;
      zacc       = 1'b1;
      // upper_zero[i]: digits i..DIGITS-1 are all zero
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zacc          = zacc && (disp_bcd[4*i +: 4] == 4'd0);
         upper_zero[i] = zacc;
      end
      blank = disp_blz && (idx != '0) && (32'(idx) >= 32'(dp_eff)) && upper_zero[idx];
      case (digit)
         4'd0:    seg_raw = 7'b1000000;
         4'd1:    seg_raw = 7'b1111001;
         4'd2:    seg_raw = 7'b0100100;
         4'd3:    seg_raw = 7'b0110000;
         4'd4:    seg_raw = 7'b0011001;
         4'd5:    seg_raw = 7'b0010010;
         4'd6:    seg_raw = 7'b0000010;
         4'd7:    seg_raw = 7'b1111000;
         4'd8:    seg_raw = 7'b0000000;
         4'd9:    seg_raw = 7'b0010000;
         default: seg_raw = 7'b0111111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an  <= '1;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= ~(DIGITS'(1) << idx);
         seg <= blank ? 7'b1111111 : seg_raw;
         dp  <= ~(32'(disp_dp) == 32'(idx) + 32'd1);
      end
   end
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIGITS=3, CLK_DIV=4: vector table of static
// displays plus exact-timing sequences for reset, handoff, stall and mid-frame reset.
module tb_seg7_scan;
   localparam int D  = 3;
   localparam int CD = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] an;
   logic [6:0] seg;
   logic       dp;

   seg7_scan_if #(.DIGITS(D)) bus ();

   seg7_scan #(.DIGITS(D), .CLK_DIV(CD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .up    (bus.slave),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0]     bcd;
      logic [3:0]      dpp;
      logic            blz;
      logic [2:0][6:0] s;     // expected seg per digit, s[i] for digit i
      logic [2:0]      dpn;   // expected dp per digit (active-low)
   } vec_t;

   vec_t       tbl [10];
   logic [6:0] segtab [16];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) tick();
      chk("rst_an", an, 3'b111);
      chk("rst_seg", seg, 7'b1111111);
      chk("rst_dp", dp, 1'b1);
      chk("rst_ready", bus.bcd_ready, 1'b1);
      rst_n = 1'b1;
   endtask

   task automatic check_idle(input string tag, input int n);
      int d;
      logic [2:0] ea;
      for (int k = 0; k < n; k++) begin
         tick();
         d  = (k / 4) % 3;
         ea = ~(3'b001 << d);
         chk($sformatf("%s_an_c%0d", tag, k), an, ea);
         chk($sformatf("%s_seg_c%0d", tag, k), seg, 7'b1000000);
         chk($sformatf("%s_dp_c%0d", tag, k), dp, 1'b1);
      end
   endtask

   task automatic send(input logic [11:0] b, input logic [3:0] p, input logic z);
      chk("send_ready_before", bus.bcd_ready, 1'b1);
      bus.bcd       = b;
      bus.dp_pos    = p;
      bus.blank_lz  = z;
      bus.bcd_valid = 1'b1;
      tick();
      bus.bcd_valid = 1'b0;
      chk("send_ready_after", bus.bcd_ready, 1'b0);
   endtask

   initial begin
      int d, f, cyc;
      logic [2:0]  ea;
      logic [11:0] fw [3];
      logic [11:0] w;

      segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                 7'b0111111};
      tbl[0] = '{12'h075, 4'd0, 1'b1, {7'b1111111, 7'b1111000, 7'b0010010}, 3'b111};
      tbl[1] = '{12'h005, 4'd2, 1'b1, {7'b1111111, 7'b1000000, 7'b0010010}, 3'b101};
      tbl[2] = '{12'hA0F, 4'd0, 1'b0, {7'b0111111, 7'b1000000, 7'b0111111}, 3'b111};
      tbl[3] = '{12'h123, 4'd3, 1'b1, {7'b1111001, 7'b0100100, 7'b0110000}, 3'b011};
      tbl[4] = '{12'h000, 4'd0, 1'b1, {7'b1111111, 7'b1111111, 7'b1000000}, 3'b111};
      tbl[5] = '{12'h000, 4'd9, 1'b1, {7'b1111111, 7'b1111111, 7'b1000000}, 3'b111};
      tbl[6] = '{12'h096, 4'd1, 1'b1, {7'b1111111, 7'b0010000, 7'b0000010}, 3'b110};
      tbl[7] = '{12'h408, 4'd0, 1'b1, {7'b0011001, 7'b1000000, 7'b0000000}, 3'b111};
      tbl[8] = '{12'h789, 4'd0, 1'b0, {7'b1111000, 7'b0000000, 7'b0010000}, 3'b111};
      tbl[9] = '{12'h000, 4'd3, 1'b1, {7'b1000000, 7'b1000000, 7'b1000000}, 3'b011};

      bus.bcd       = '0;
      bus.dp_pos    = '0;
      bus.blank_lz  = 1'b0;
      bus.bcd_valid = 1'b0;

      // Idle scan after reset
      do_reset(3);
      check_idle("idle", 24);

      // Word sent at cycle 2 appears exactly after the first frame boundary
      do_reset(1);
      tick();
      chk("b_ready_c1", bus.bcd_ready, 1'b1);
      bus.bcd = 12'h075; bus.dp_pos = 4'd0; bus.blank_lz = 1'b1; bus.bcd_valid = 1'b1;
      for (int k = 2; k <= 24; k++) begin
         tick();
         if (k == 2) bus.bcd_valid = 1'b0;
         chk($sformatf("b_ready_c%0d", k), bus.bcd_ready, (k >= 12) ? 1'b1 : 1'b0);
         if (k <= 12) begin
            chk($sformatf("b_seg_c%0d", k), seg, 7'b1000000);
         end else begin
            d  = (k - 13) / 4;
            ea = ~(3'b001 << d);
            chk($sformatf("b_an_c%0d", k), an, ea);
            chk($sformatf("b_seg_c%0d", k), seg, tbl[0].s[d]);
            chk($sformatf("b_dp_c%0d", k), dp, 1'b1);
         end
      end

      // Back-to-back words: second stalls, each frame shows exactly one word
      do_reset(1);
      fw[0] = 12'h000; fw[1] = 12'h123; fw[2] = 12'h456;
      bus.dp_pos = 4'd0; bus.blank_lz = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         tick();
         if (k == 1) begin bus.bcd = 12'h123; bus.bcd_valid = 1'b1; end
         if (k == 2) bus.bcd = 12'h456;
         if (k == 13) bus.bcd_valid = 1'b0;
         chk($sformatf("c_ready_c%0d", k), bus.bcd_ready,
             (k == 1 || k == 12 || k >= 24) ? 1'b1 : 1'b0);
         f  = (k - 1) / 12;
         d  = ((k - 1) / 4) % 3;
         ea = ~(3'b001 << d);
         w  = fw[f];
         chk($sformatf("c_an_c%0d", k), an, ea);
         chk($sformatf("c_seg_c%0d", k), seg, segtab[w[4*d +: 4]]);
         chk($sformatf("c_dp_c%0d", k), dp, 1'b1);
      end

      // Vector table: each word observed over one full frame
      for (int v = 0; v < 10; v++) begin
         send(tbl[v].bcd, tbl[v].dpp, tbl[v].blz);
         cyc = 0;
         while (!bus.bcd_ready && cyc < 40) begin
            tick();
            cyc++;
         end
         chk($sformatf("vec%0d_handoff", v), bus.bcd_ready, 1'b1);
         for (int k = 0; k < 12; k++) begin
            tick();
            d  = k / 4;
            ea = ~(3'b001 << d);
            chk($sformatf("vec%0d_an_c%0d", v, k), an, ea);
            chk($sformatf("vec%0d_seg_d%0d", v, d), seg, tbl[v].s[d]);
            chk($sformatf("vec%0d_dp_d%0d", v, d), dp, tbl[v].dpn[d]);
         end
      end

      // Reset mid-frame with a pending word and valid high during reset
      send(12'h321, 4'd1, 1'b1);
      tick();
      tick();
      chk("d_pending", bus.bcd_ready, 1'b0);
      bus.bcd = 12'h999; bus.bcd_valid = 1'b1;
      do_reset(1);
      bus.bcd_valid = 1'b0;
      check_idle("d_idle", 24);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
